// File: rtl/action_sequencer.sv
// Turn-based action front end: synchronizes raw player buttons, latches one action per
// player per collection window, then issues both under a timed enable pulse.
module action_sequencer #(
  parameter int unsigned WINDOW_CYCLES = 16,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       resetGame,
  input  logic [3:0] btn1,
  input  logic [3:0] btn2,
  input  logic       gameOver,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       committed1,
  output logic       committed2,
  output logic [7:0] turnCount
);

  localparam int unsigned MAX_WP  = (WINDOW_CYCLES > PULSE_CYCLES) ? WINDOW_CYCLES : PULSE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_WP > GAP_CYCLES) ? MAX_WP : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_GAP     = 2'd2;
  localparam logic [1:0] S_FROZEN  = 2'd3;

  localparam logic [2:0] ACT_IDLE   = 3'b000;
  localparam logic [2:0] ACT_LEFT   = 3'b001;
  localparam logic [2:0] ACT_RIGHT  = 3'b010;
  localparam logic [2:0] ACT_ATTACK = 3'b011;
  localparam logic [2:0] ACT_DEFEND = 3'b100;

  // Priority decode of one player's edge events: {valid, code}.
  function automatic logic [3:0] decode(input logic [3:0] ev);
    logic [3:0] r;
    r = {1'b0, ACT_IDLE};
    if (ev[2]) begin
      r = {1'b1, ACT_ATTACK};
    end else if (ev[3]) begin
      r = {1'b1, ACT_DEFEND};
    end else if (ev[0] && ev[1]) begin
      r = {1'b0, ACT_IDLE};
    end else if (ev[0]) begin
      r = {1'b1, ACT_LEFT};
    end else if (ev[1]) begin
      r = {1'b1, ACT_RIGHT};
    end
    return r;
  endfunction

  logic [3:0] b1_s1_q, b1_s2_q, b1_prev_q;
  logic [3:0] b2_s1_q, b2_s2_q, b2_prev_q;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code1_q, code1_d, code2_q, code2_d;
  logic             com1_q, com1_d, com2_q, com2_d;
  logic [2:0]       act1_q, act1_d, act2_q, act2_d;
  logic             en_q, en_d;
  logic [7:0]       turn_q, turn_d;

  logic [3:0] ev1_c, ev2_c;
  logic [3:0] dec1_c, dec2_c;
  logic       take1_c, take2_c;
  logic       com1_now_c, com2_now_c;
  logic [2:0] code1_now_c, code2_now_c;

  // Two-flop synchronizers plus edge history; these run in every state.
  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      b1_s1_q   <= '0;
      b1_s2_q   <= '0;
      b1_prev_q <= '0;
      b2_s1_q   <= '0;
      b2_s2_q   <= '0;
      b2_prev_q <= '0;
    end else begin
      b1_s1_q   <= btn1;
      b1_s2_q   <= b1_s1_q;
      b1_prev_q <= b1_s2_q;
      b2_s1_q   <= btn2;
      b2_s2_q   <= b2_s1_q;
      b2_prev_q <= b2_s2_q;
    end
  end

  assign ev1_c  = b1_s2_q & ~b1_prev_q;
  assign ev2_c  = b2_s2_q & ~b2_prev_q;
  assign dec1_c = decode(ev1_c);
  assign dec2_c = decode(ev2_c);

  // A commit is only taken in COLLECT by a player that has not yet committed.
  assign take1_c     = (state_q == S_COLLECT) && !com1_q && dec1_c[3];
  assign take2_c     = (state_q == S_COLLECT) && !com2_q && dec2_c[3];
  assign com1_now_c  = com1_q | take1_c;
  assign com2_now_c  = com2_q | take2_c;
  assign code1_now_c = take1_c ? dec1_c[2:0] : code1_q;
  assign code2_now_c = take2_c ? dec2_c[2:0] : code2_q;

  always_ff @(posedge clk or negedge resetGame) begin
    if (!resetGame) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      code1_q <= ACT_IDLE;
      code2_q <= ACT_IDLE;
      com1_q  <= 1'b0;
      com2_q  <= 1'b0;
      act1_q  <= ACT_IDLE;
      act2_q  <= ACT_IDLE;
      en_q    <= 1'b0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code1_q <= code1_d;
      code2_q <= code2_d;
      com1_q  <= com1_d;
      com2_q  <= com2_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      en_q    <= en_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code1_d = code1_q;
    code2_d = code2_q;
    com1_d  = com1_q;
    com2_d  = com2_q;
    act1_d  = act1_q;
    act2_d  = act2_q;
    en_d    = en_q;
    turn_d  = turn_q;

    case (state_q)
      S_COLLECT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        com1_d  = com1_now_c;
        com2_d  = com2_now_c;
        code1_d = code1_now_c;
        code2_d = code2_now_c;
        if ((com1_now_c && com2_now_c) || (cnt_q == WIN_LAST)) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          act1_d  = code1_now_c;
          act2_d  = code2_now_c;
          en_d    = 1'b1;
          if (turn_q != 8'hFF) begin
            turn_d = turn_q + 8'd1;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == PULSE_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_LAST) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
          com1_d  = 1'b0;
          com2_d  = 1'b0;
          code1_d = ACT_IDLE;
          code2_d = ACT_IDLE;
        end
      end
      S_FROZEN: begin
        state_d = S_COLLECT;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_COLLECT;
        cnt_d   = '0;
      end
    endcase

    // Freeze overrides every state and truncates any pulse in progress.
    if (gameOver) begin
      state_d = S_FROZEN;
      cnt_d   = '0;
      code1_d = ACT_IDLE;
      code2_d = ACT_IDLE;
      com1_d  = 1'b0;
      com2_d  = 1'b0;
      act1_d  = ACT_IDLE;
      act2_d  = ACT_IDLE;
      en_d    = 1'b0;
    end
  end

  assign action1      = act1_q;
  assign action2      = act2_q;
  assign actionEnable = en_q;
  assign committed1   = com1_q;
  assign committed2   = com2_q;
  assign turnCount    = turn_q;

endmodule

// File: tb/tb_action_sequencer.sv
// Directed bench for action_sequencer: scoreboard of expected action pairs popped on each
// actionEnable rise, plus step-by-step checks of commit timing, freeze, reset and saturation.
module tb_action_sequencer;

  logic       clk = 1'b0;
  logic       resetGame = 1'b1;
  logic [3:0] btn1 = 4'b0;
  logic [3:0] btn2 = 4'b0;
  logic       gameOver = 1'b0;
  logic [2:0] action1, action2;
  logic       actionEnable, committed1, committed2;
  logic [7:0] turnCount;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];
  logic en_prev = 1'b0;

  action_sequencer #(
    .WINDOW_CYCLES(16),
    .PULSE_CYCLES (2),
    .GAP_CYCLES   (2)
  ) dut (
    .clk         (clk),
    .resetGame   (resetGame),
    .btn1        (btn1),
    .btn2        (btn2),
    .gameOver    (gameOver),
    .action1     (action1),
    .action2     (action2),
    .actionEnable(actionEnable),
    .committed1  (committed1),
    .committed2  (committed2),
    .turnCount   (turnCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_en(input int budget, output int n);
    n = 0;
    while (!actionEnable && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("enable_within_budget", 32'(actionEnable), 32'd1);
  endtask

  task automatic pulse_len(output int n);
    n = 0;
    do begin
      n++;
      @(negedge clk);
    end while (actionEnable && n < 20);
  endtask

  // Reference action code for one player's simultaneous rising buttons.
  function automatic logic [2:0] exp_code(input logic [3:0] b);
    if (b[2]) return 3'd3;
    if (b[3]) return 3'd4;
    if (b[0] && b[1]) return 3'd0;
    if (b[0]) return 3'd1;
    if (b[1]) return 3'd2;
    return 3'd0;
  endfunction

  // Scoreboard: every enable rise must match the oldest expected action pair.
  always @(negedge clk) begin
    logic [5:0] e;
    if (actionEnable && !en_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_action1", 32'(action1), 32'(e[5:3]));
        chk("sb_action2", 32'(action2), 32'(e[2:0]));
      end
    end
    en_prev <= actionEnable;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int hi;
    logic [3:0] p1, p2;

    #2 resetGame = 1'b0;
    cyc(2);
    chk("rst_enable", 32'(actionEnable), 32'd0);
    chk("rst_action1", 32'(action1), 32'd0);
    chk("rst_action2", 32'(action2), 32'd0);
    chk("rst_committed1", 32'(committed1), 32'd0);
    chk("rst_committed2", 32'(committed2), 32'd0);
    chk("rst_turns", 32'(turnCount), 32'd0);
    resetGame = 1'b1;

    // 1: attack then defend, both commit -> immediate issue
    btn1 = 4'b0100;
    cyc(2);
    btn2 = 4'b1000;
    exp_q.push_back({3'd3, 3'd4});
    cyc(1);
    chk("t1_c1_rise", 32'(committed1), 32'd1);
    chk("t1_c2_low", 32'(committed2), 32'd0);
    chk("t1_en_low", 32'(actionEnable), 32'd0);
    cyc(1);
    chk("t1_en_still_low", 32'(actionEnable), 32'd0);
    cyc(1);
    chk("t1_c2_rise", 32'(committed2), 32'd1);
    chk("t1_en_rise", 32'(actionEnable), 32'd1);
    chk("t1_action1", 32'(action1), 32'd3);
    chk("t1_action2", 32'(action2), 32'd4);
    chk("t1_turns", 32'(turnCount), 32'd1);
    cyc(1);
    chk("t1_en_hold", 32'(actionEnable), 32'd1);
    cyc(1);
    chk("t1_en_drop", 32'(actionEnable), 32'd0);
    chk("t1_gap_action_held", 32'(action1), 32'd3);
    cyc(2);
    chk("t1_c1_clear", 32'(committed1), 32'd0);
    chk("t1_c2_clear", 32'(committed2), 32'd0);
    chk("t1_action_kept", 32'(action2), 32'd4);

    // 2: only player 1 moves left, window times out
    btn1 = 4'b0001;
    btn2 = 4'b0000;
    exp_q.push_back({3'd1, 3'd0});
    wait_en(40, n);
    chk("t2_timeout_cycles", 32'(n), 32'd16);
    chk("t2_c1", 32'(committed1), 32'd1);
    chk("t2_c2", 32'(committed2), 32'd0);
    pulse_len(n);
    chk("t2_pulse_len", 32'(n), 32'd2);
    cyc(2);

    // 3: left+right together ignored, then right alone commits; held btn1 cannot re-commit
    btn2 = 4'b0011;
    cyc(4);
    chk("t3_lr_ignored", 32'(committed2), 32'd0);
    btn2 = 4'b0000;
    cyc(3);
    btn2 = 4'b0010;
    exp_q.push_back({3'd0, 3'd2});
    cyc(3);
    chk("t3_right_commit", 32'(committed2), 32'd1);
    chk("t3_held_no_commit", 32'(committed1), 32'd0);
    wait_en(40, n);
    chk("t3_timeout_cycles", 32'(n), 32'd6);
    chk("t3_c1_at_issue", 32'(committed1), 32'd0);
    chk("t3_turns", 32'(turnCount), 32'd3);
    pulse_len(n);
    cyc(2);

    // 4: second press after commit is ignored; attack+defend+left commits attack
    btn1 = 4'b0000;
    cyc(1);
    btn1 = 4'b0100;
    cyc(3);
    chk("t4_c1", 32'(committed1), 32'd1);
    chk("t4_c2", 32'(committed2), 32'd0);
    btn1 = 4'b1000;
    cyc(4);
    chk("t4_c1_kept", 32'(committed1), 32'd1);
    chk("t4_no_issue_yet", 32'(actionEnable), 32'd0);
    btn2 = 4'b1101;
    exp_q.push_back({3'd3, 3'd3});
    wait_en(40, n);
    chk("t4_sync_latency", 32'(n), 32'd3);
    pulse_len(n);
    cyc(2);

    // 5: gameOver in first pulse cycle freezes the block
    btn1 = 4'b0000;
    btn2 = 4'b0000;
    cyc(1);
    btn1 = 4'b0001;
    btn2 = 4'b0010;
    exp_q.push_back({3'd1, 3'd2});
    wait_en(40, n);
    chk("t5_both_commit_latency", 32'(n), 32'd3);
    gameOver = 1'b1;
    cyc(1);
    chk("t5_en_truncated", 32'(actionEnable), 32'd0);
    chk("t5_action1_zero", 32'(action1), 32'd0);
    chk("t5_action2_zero", 32'(action2), 32'd0);
    chk("t5_c1_zero", 32'(committed1), 32'd0);
    chk("t5_turns_held", 32'(turnCount), 32'd5);
    btn1 = 4'b0000;
    btn2 = 4'b0000;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        btn1 = 4'b0100;
        btn2 = 4'b1000;
      end
      cyc(1);
      if (actionEnable) hi++;
    end
    chk("t5_frozen_no_enable", 32'(hi), 32'd0);
    chk("t5_frozen_turns", 32'(turnCount), 32'd5);
    gameOver = 1'b0;
    exp_q.push_back({3'd0, 3'd0});
    wait_en(40, n);
    chk("t5_window_restart", 32'(n), 32'd17);
    chk("t5_turns_after", 32'(turnCount), 32'd6);

    // 6: asynchronous reset in the middle of a pulse
    resetGame = 1'b0;
    #1;
    chk("t6_async_en", 32'(actionEnable), 32'd0);
    chk("t6_async_action1", 32'(action1), 32'd0);
    chk("t6_async_turns", 32'(turnCount), 32'd0);
    chk("t6_async_c2", 32'(committed2), 32'd0);
    chk("t6_sb_drained", 32'(exp_q.size()), 32'd0);
    btn1 = 4'b0000;
    btn2 = 4'b0000;
    @(negedge clk);
    resetGame = 1'b1;

    // Turn-count saturation with random simultaneous button patterns
    for (int t = 0; t < 256; t++) begin
      btn1 = 4'b0000;
      btn2 = 4'b0000;
      cyc(2);
      p1 = 4'($urandom_range(1, 15));
      p2 = 4'($urandom_range(1, 15));
      btn1 = p1;
      btn2 = p2;
      exp_q.push_back({exp_code(p1), exp_code(p2)});
      wait_en(40, n);
      chk("sat_turns", 32'(turnCount), (t < 255) ? 32'(t + 1) : 32'd255);
      pulse_len(n);
      chk("sat_pulse_len", 32'(n), 32'd2);
      cyc(2);
    end
    chk("sat_final", 32'(turnCount), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/action_sequencer.md
Name: action_sequencer

Overview:
- Upstream front end of the fighting-game core.
- Converts raw, asynchronous per-player button inputs into the 3-bit action codes `action1`/`action2` and the `actionEnable` strobe that the game core consumes.
- Each turn is a fixed-length collection window. Each player commits at most one action per window.
- The block then issues both actions together under a timed enable pulse and freezes while the game is over.

Parameters:
- WINDOW_CYCLES, 16, max cycles spent in COLLECT before forced issue (≥2)
- PULSE_CYCLES, 2, cycles actionEnable is held high per turn (≥1)
- GAP_CYCLES, 2, cycles actionEnable is held low after a pulse before the next window opens (≥1)

Ports:
- clk  input  1  system clock, all state on rising edge
- resetGame  input  1  asynchronous, active-low reset
- btn1  input  4  player 1 raw buttons: [0] left, [1] right, [2] attack, [3] defend
- btn2  input  4  player 2 raw buttons, same bit map
- gameOver  input  1  synchronous freeze request, high = game finished
- action1  output  3  player 1 action code
- action2  output  3  player 2 action code
- actionEnable  output  1  turn strobe to game core
- committed1  output  1  player 1 has locked an action this window
- committed2  output  1  player 2 has locked an action this window
- turnCount  output  8  number of issued turns, saturating

Behaviour:
- Action codes:
  - 000 idle
  - 001 move left
  - 010 move right
  - 011 attack
  - 100 defend
  - 101–111 never produced.
- Reset (resetGame low, asynchronous):
  - State = COLLECT, window counter = 0.
  - Synchronizer and edge-history flops = 0.
  - action1 = action2 = 000, actionEnable = 0, committed1/2 = 0, turnCount = 0.
- Input path, per button bit:
  - Two-flop synchronizer, then rising-edge detect against the previous synchronized value.
  - A button going high before edge k produces an edge event evaluated at edge k+2.
- Priority when several edge events of one player occur in the same cycle: attack > defend > left > right.
  - left and right together with no attack/defend: the event is ignored, and the player does not commit.
- All outputs are registered.
- COLLECT:
  - Window counter increments each cycle.
  - An uncommitted player's first valid edge event latches its code and sets committedN.
  - Further events that window are ignored.
  - Leave to ISSUE on the edge where both players are committed (including the edge of the second commit, or both committing together).
  - Also leave to ISSUE on the edge where counter == WINDOW_CYCLES-1.
  - Timeout takes precedence only in that the current-edge commits are still captured.
  - An uncommitted player issues 000.
- Entering ISSUE, at the same edge:
  - action1/action2 load the latched codes.
  - actionEnable goes 1.
  - turnCount increments, saturating at 255.
- ISSUE:
  - actionEnable stays 1 for exactly PULSE_CYCLES cycles, then the block enters GAP.
  - Actions are stable throughout.
- GAP:
  - actionEnable = 0 for GAP_CYCLES cycles.
  - Actions still held.
  - Button events are ignored, but synchronizer history keeps updating.
  - On exit to COLLECT: committed1/2 clear, counter = 0, latched codes clear.
  - action1/action2 keep the last issued value until the next ISSUE entry.
- FROZEN:
  - gameOver sampled high at any edge in any state moves the block to FROZEN at that edge.
  - In FROZEN: actionEnable = 0, action1/action2 = 000, committed1/2 = 0, counter = 0.
  - A pulse in progress is truncated.
  - Remain frozen while gameOver = 1.
  - The first edge with gameOver = 0 enters COLLECT.
  - turnCount is held.
- Reset mid-pulse: actionEnable drops immediately (asynchronous), and all state returns to reset values.

Test Plan:
1. Reset, then btn1[2] high at edge 10 and btn2[3] high at edge 12.
   - committed1 rises at edge 12.
   - committed2 and actionEnable rise at edge 14 with action1 = 011, action2 = 100.
   - actionEnable low at edge 16.
   - turnCount = 1.
2. Only btn1[0] pressed, WINDOW_CYCLES = 16.
   - Forced issue 16 cycles after window opens, with action1 = 001, action2 = 000.
   - Pulse length 2 cycles.
3. btn2[0] and btn2[1] rise together.
   - No commit.
   - Later btn2[1] alone (after release) commits 010.
   - btn2 with [2],[3],[0] together commits 011.
4. Button held high across the window, then a second press after commit.
   - Only one edge counted; second press ignored.
   - Held button does not re-commit in the next window without a new rising edge.
5. gameOver raised during first pulse cycle.
   - Next edge: actionEnable = 0, actions = 000, no further turns while high.
   - After release, the window restarts at counter 0.
6. resetGame low mid-ISSUE.
   - Outputs are 0 immediately.
   - After release, 256 turns driven give turnCount saturating at 255.
